dmi_resp_agent: RTL and testbench

//  Core-side responder for the JTAG DMI request/response channel. Accepts one
//  {addr,data,op} request at a time from the DMI interconnect and runs it as a

---
 rtl/dmi_resp_agent.sv | 125 ++++++++++++
 tb/tb_dmi_resp_agent.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmi_resp_agent.sv
// DMI responder: takes one {addr,data,op} request, runs it on the debug-module
// register bus with a bounded wait for dm_ack, and returns {data,status}.
module dmi_resp_agent #(
  parameter int DMI_ADDR_WIDTH = 7,
  parameter int DMI_DATA_WIDTH = 32,
  parameter int DMI_OP_WIDTH   = 2,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int TX_WIDTH = DMI_ADDR_WIDTH + DMI_DATA_WIDTH + DMI_OP_WIDTH,
  localparam int RX_WIDTH = DMI_DATA_WIDTH + DMI_OP_WIDTH
) (
  input  logic                      clk,
  input  logic                      dev_rst_n,
  input  logic                      req_vld,
  input  logic [TX_WIDTH-1:0]       req_data,
  output logic                      req_rdy,
  output logic                      resp_vld,
  output logic [RX_WIDTH-1:0]       resp_data,
  input  logic                      resp_rdy,
  output logic [DMI_ADDR_WIDTH-1:0] dm_addr,
  output logic [DMI_DATA_WIDTH-1:0] dm_wdata,
  output logic                      dm_rd,
  output logic                      dm_wr,
  input  logic [DMI_DATA_WIDTH-1:0] dm_rdata,
  input  logic                      dm_ack,
  input  logic                      dm_err,
  output logic [1:0]                o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [DMI_OP_WIDTH-1:0] OP_NOP  = DMI_OP_WIDTH'(0);
  localparam logic [DMI_OP_WIDTH-1:0] OP_RD   = DMI_OP_WIDTH'(1);
  localparam logic [DMI_OP_WIDTH-1:0] OP_WR   = DMI_OP_WIDTH'(2);
  localparam logic [DMI_OP_WIDTH-1:0] ST_OK   = DMI_OP_WIDTH'(0);
  localparam logic [DMI_OP_WIDTH-1:0] ST_FAIL = DMI_OP_WIDTH'(2);
  localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]        CNT_TO  = CNT_W'(TIMEOUT_CYCLES - 2);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid and its data hold stable until that edge.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [DMI_OP_WIDTH-1:0]   r_op;
  logic [DMI_ADDR_WIDTH-1:0] r_addr;
  logic [DMI_DATA_WIDTH-1:0] r_wdata;
  logic [RX_WIDTH-1:0]       r_resp;
  logic [CNT_W-1:0]          r_cnt;

  logic [DMI_OP_WIDTH-1:0]   w_req_op;
  logic                      w_req_bus;
  logic                      w_timeout;

  assign w_req_op  = req_data[DMI_OP_WIDTH-1:0];
  assign w_req_bus = (w_req_op == OP_RD) || (w_req_op == OP_WR);
  // Timeout fires on the edge where the counter reaches TIMEOUT_CYCLES-1.
  assign w_timeout = (r_cnt == CNT_TO);

  always_ff @(posedge clk or negedge dev_rst_n) begin
    if (!dev_rst_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_vld) w_next = w_req_bus ? ACCESS : RESP;
      ACCESS:  if (dm_ack || w_timeout) w_next = RESP;
      RESP:    if (resp_rdy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge dev_rst_n) begin
    if (!dev_rst_n) begin
      r_op    <= OP_NOP;
      r_addr  <= '0;
      r_wdata <= '0;
      r_resp  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_vld) begin
            r_op <= w_req_op;
            if (w_req_bus) begin
              r_addr  <= req_data[TX_WIDTH-1 -: DMI_ADDR_WIDTH];
              r_wdata <= req_data[DMI_OP_WIDTH +: DMI_DATA_WIDTH];
              r_cnt   <= '0;
            end else begin
              r_resp <= {DMI_DATA_WIDTH'(0), (w_req_op == OP_NOP) ? ST_OK : ST_FAIL};
            end
          end
        end
        ACCESS: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          // Ack takes priority over a coincident timeout.
          if (dm_ack) begin
            if (dm_err)              r_resp <= {DMI_DATA_WIDTH'(0), ST_FAIL};
            else if (r_op == OP_RD)  r_resp <= {dm_rdata, ST_OK};
            else                     r_resp <= {DMI_DATA_WIDTH'(0), ST_OK};
          end else if (w_timeout) begin
            r_resp <= {DMI_DATA_WIDTH'(0), ST_FAIL};
          end
        end
        default: ;
      endcase
    end
  end

  assign req_rdy     = (r_state == IDLE);
  assign resp_vld    = (r_state == RESP);
  assign resp_data   = r_resp;
  assign dm_addr     = r_addr;
  assign dm_wdata    = r_wdata;
  assign dm_rd       = (r_state == ACCESS) && (r_op == OP_RD);
  assign dm_wr       = (r_state == ACCESS) && (r_op == OP_WR);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmi_resp_agent.sv
// Directed bench for dmi_resp_agent: read/write/timeout/error/NOP/reserved op,
// response stall, stray ack and mid-access reset.
module tb_dmi_resp_agent;

  logic        clk;
  logic        dev_rst_n;
  logic        req_vld;
  logic [40:0] req_data;
  logic        req_rdy;
  logic        resp_vld;
  logic [33:0] resp_data;
  logic        resp_rdy;
  logic [6:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        dm_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  dmi_resp_agent dut (
    .clk(clk), .dev_rst_n(dev_rst_n),
    .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .resp_vld(resp_vld), .resp_data(resp_data), .resp_rdy(resp_rdy),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
    .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and plays the bus: ack (with err) on the ack_after-th
  // strobe cycle, ack_after=0 means never ack. Returns what was observed.
  task automatic run_req(input logic [6:0] addr, input logic [31:0] data,
                         input logic [1:0] op, input int ack_after,
                         input logic err, input logic [31:0] rdata,
                         output int rd_cyc, output int wr_cyc, output int lat,
                         output logic [33:0] resp, output logic [6:0] addr_seen,
                         output logic [31:0] wdata_seen, output logic both);
    rd_cyc = 0; wr_cyc = 0; lat = 0; both = 1'b0;
    addr_seen = '0; wdata_seen = '0;
    for (int i = 0; i < 20 && !req_rdy; i++) @(posedge clk);
    #1;
    req_data = {addr, data, op};
    req_vld  = 1'b1;
    @(posedge clk); #1;
    req_vld = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      lat = cyc;
      if (resp_vld) break;
      if (dm_rd && dm_wr) both = 1'b1;
      if (dm_rd) rd_cyc++;
      if (dm_wr) wr_cyc++;
      if (dm_rd || dm_wr) begin
        addr_seen  = dm_addr;
        wdata_seen = dm_wdata;
        if (ack_after > 0 && (rd_cyc + wr_cyc) == ack_after) begin
          dm_ack = 1'b1; dm_err = err; dm_rdata = rdata;
        end
      end
      @(posedge clk); #1;
      dm_ack = 1'b0; dm_err = 1'b0; dm_rdata = '0;
    end
    resp = resp_data;
  endtask

  task automatic handshake();
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_rdy got %0b exp 1", req_rdy); end
    checks++; if (resp_vld !== 1'b0) begin errors++; $display("FAIL reset_resp_vld got %0b exp 0", resp_vld); end
    checks++; if ({dm_rd, dm_wr} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {dm_rd, dm_wr}); end
    checks++; if (resp_data !== 34'h0) begin errors++; $display("FAIL reset_resp_data got %h exp 0", resp_data); end
    checks++; if ({dm_addr, dm_wdata} !== 39'h0) begin errors++; $display("FAIL reset_bus got %h/%h exp 0/0", dm_addr, dm_wdata); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_read();
    int rc, wc, lat; logic [33:0] r; logic [6:0] a; logic [31:0] w; logic b;
    run_req(7'h11, 32'h0, 2'd1, 3, 1'b0, 32'hDEADBEEF, rc, wc, lat, r, a, w, b);
    checks++; if (rc !== 3 || wc !== 0) begin errors++; $display("FAIL rd_strobe got rd=%0d wr=%0d exp rd=3 wr=0", rc, wc); end
    checks++; if (a !== 7'h11) begin errors++; $display("FAIL rd_addr got %h exp 11", a); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency got %0d exp 4", lat); end
    checks++; if (r !== {32'hDEADBEEF, 2'd0}) begin errors++; $display("FAIL rd_resp got %h exp %h", r, {32'hDEADBEEF, 2'd0}); end
    handshake();
    checks++; if (resp_vld !== 1'b0 || req_rdy !== 1'b1) begin errors++; $display("FAIL rd_release got vld=%0b rdy=%0b exp 0/1", resp_vld, req_rdy); end
  endtask

  task automatic test_write();
    int rc, wc, lat; logic [33:0] r; logic [6:0] a; logic [31:0] w; logic b;
    run_req(7'h10, 32'h1, 2'd2, 1, 1'b0, 32'hFFFF_FFFF, rc, wc, lat, r, a, w, b);
    checks++; if (wc !== 1 || rc !== 0) begin errors++; $display("FAIL wr_strobe got rd=%0d wr=%0d exp rd=0 wr=1", rc, wc); end
    checks++; if (a !== 7'h10 || w !== 32'h1) begin errors++; $display("FAIL wr_bus got %h/%h exp 10/1", a, w); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d exp 2", lat); end
    checks++; if (r !== 34'h0) begin errors++; $display("FAIL wr_resp got %h exp 0", r); end
    handshake();
  endtask

  task automatic test_timeout();
    int rc, wc, lat; logic [33:0] r; logic [6:0] a; logic [31:0] w; logic b;
    run_req(7'h22, 32'h0, 2'd1, 0, 1'b0, 32'h0, rc, wc, lat, r, a, w, b);
    checks++; if (rc !== 63) begin errors++; $display("FAIL to_strobe got %0d exp 63", rc); end
    checks++; if (lat !== 64) begin errors++; $display("FAIL to_latency got %0d exp 64", lat); end
    checks++; if (r !== {32'h0, 2'd2}) begin errors++; $display("FAIL to_resp got %h exp 2", r); end
    handshake();
    // Ack on the very last strobe cycle must win over the timeout.
    run_req(7'h23, 32'h0, 2'd1, 63, 1'b0, 32'h1234_5678, rc, wc, lat, r, a, w, b);
    checks++; if (r !== {32'h1234_5678, 2'd0}) begin errors++; $display("FAIL to_ack_wins got %h exp %h", r, {32'h1234_5678, 2'd0}); end
    handshake();
  endtask

  task automatic test_error();
    int rc, wc, lat; logic [33:0] r; logic [6:0] a; logic [31:0] w; logic b;
    run_req(7'h05, 32'hA5A5_A5A5, 2'd2, 2, 1'b1, 32'hCAFE_F00D, rc, wc, lat, r, a, w, b);
    checks++; if (wc !== 2 || b !== 1'b0) begin errors++; $display("FAIL err_strobe got wr=%0d both=%0b exp 2/0", wc, b); end
    checks++; if (r !== {32'h0, 2'd2}) begin errors++; $display("FAIL err_resp got %h exp 2", r); end
    handshake();
    // A read with error must not leak the read data either.
    run_req(7'h06, 32'h0, 2'd1, 1, 1'b1, 32'hCAFE_F00D, rc, wc, lat, r, a, w, b);
    checks++; if (r !== {32'h0, 2'd2}) begin errors++; $display("FAIL err_rd_resp got %h exp 2", r); end
    handshake();
  endtask

  task automatic test_nop_reserved();
    int rc, wc, lat; logic [33:0] r; logic [6:0] a; logic [31:0] w; logic b;
    run_req(7'h11, 32'h5555_5555, 2'd0, 1, 1'b0, 32'h0, rc, wc, lat, r, a, w, b);
    checks++; if (rc + wc !== 0) begin errors++; $display("FAIL nop_strobe got %0d exp 0", rc + wc); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL nop_latency got %0d exp 1", lat); end
    checks++; if (r !== 34'h0) begin errors++; $display("FAIL nop_resp got %h exp 0", r); end
    handshake();
    run_req(7'h12, 32'h7777_7777, 2'd3, 1, 1'b0, 32'h0, rc, wc, lat, r, a, w, b);
    checks++; if (rc + wc !== 0 || lat !== 1) begin errors++; $display("FAIL op3_timing got strobes=%0d lat=%0d exp 0/1", rc + wc, lat); end
    checks++; if (r !== {32'h0, 2'd2}) begin errors++; $display("FAIL op3_resp got %h exp 2", r); end
    handshake();
  endtask

  task automatic test_resp_stall();
    int rc, wc, lat; logic [33:0] r; logic [6:0] a; logic [31:0] w; logic b;
    run_req(7'h30, 32'h0, 2'd1, 2, 1'b0, 32'h0BAD_CAFE, rc, wc, lat, r, a, w, b);
    req_data = {7'h31, 32'h0, 2'd1};
    req_vld  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (resp_vld !== 1'b1 || req_rdy !== 1'b0 || resp_data !== {32'h0BAD_CAFE, 2'd0}) begin
        errors++;
        $display("FAIL stall_cyc%0d got vld=%0b rdy=%0b data=%h exp 1/0/%h", i, resp_vld, req_rdy, resp_data, {32'h0BAD_CAFE, 2'd0});
      end
      @(posedge clk); #1;
    end
    req_vld = 1'b0;
    handshake();
    checks++; if (dbg_state !== 2'd0 || dm_rd !== 1'b0) begin errors++; $display("FAIL stall_no_overlap got state=%0d rd=%0b exp 0/0", dbg_state, dm_rd); end
  endtask

  task automatic test_stray_ack();
    int rc, wc, lat; logic [33:0] r; logic [6:0] a; logic [31:0] w; logic b;
    dm_ack = 1'b1; dm_err = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_rdy !== 1'b1 || resp_vld !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL stray_ack got rdy=%0b vld=%0b state=%0d exp 1/0/0", req_rdy, resp_vld, dbg_state); end
    dm_ack = 1'b0; dm_err = 1'b0; dm_rdata = '0;
    run_req(7'h01, 32'h0, 2'd0, 1, 1'b0, 32'h0, rc, wc, lat, r, a, w, b);
    checks++; if (r !== 34'h0) begin errors++; $display("FAIL stray_after_resp got %h exp 0", r); end
    handshake();
  endtask

  task automatic test_reset_mid_access();
    int rc, wc, lat; logic [33:0] r; logic [6:0] a; logic [31:0] w; logic b;
    req_data = {7'h44, 32'h0, 2'd1};
    req_vld  = 1'b1;
    @(posedge clk); #1;
    req_vld = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    checks++; if (dm_rd !== 1'b1) begin errors++; $display("FAIL rst_pre_rd got %0b exp 1", dm_rd); end
    dev_rst_n = 1'b0;
    #1;
    checks++; if (dm_rd !== 1'b0 || resp_vld !== 1'b0 || req_rdy !== 1'b1) begin errors++; $display("FAIL rst_async_ctrl got rd=%0b vld=%0b rdy=%0b exp 0/0/1", dm_rd, resp_vld, req_rdy); end
    checks++; if (dm_addr !== 7'h0 || resp_data !== 34'h0) begin errors++; $display("FAIL rst_async_data got %h/%h exp 0/0", dm_addr, resp_data); end
    @(negedge clk);
    dev_rst_n = 1'b1;
    run_req(7'h11, 32'h0, 2'd1, 2, 1'b0, 32'h1357_9BDF, rc, wc, lat, r, a, w, b);
    checks++; if (rc !== 2 || lat !== 3) begin errors++; $display("FAIL rst_post_rd got rd=%0d lat=%0d exp 2/3", rc, lat); end
    checks++; if (r !== {32'h1357_9BDF, 2'd0}) begin errors++; $display("FAIL rst_post_resp got %h exp %h", r, {32'h1357_9BDF, 2'd0}); end
    handshake();
  endtask

  initial begin
    dev_rst_n = 1'b0;
    req_vld = 1'b0; req_data = '0; resp_rdy = 1'b0;
    dm_rdata = '0; dm_ack = 1'b0; dm_err = 1'b0;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    dev_rst_n = 1'b1;
    @(posedge clk); #1;
    test_read();
    test_write();
    test_timeout();
    test_error();
    test_nop_reserved();
    test_resp_stall();
    test_stray_ack();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
